// File: rtl/event_fifo_arb_pkg.sv
// event_fifo_pkg: shared constants and the round-robin pick helper for the
// event_fifo_arb multi-channel event FIFO.
//   FIFO_WIDTH  default data word width (graph_conv neighbour word)
//   MAX_DEGREE  default per-channel depth
//   MAX_CH      largest supported channel count
//   READ_STD / READ_FWFT  values accepted by the READ_MODE parameter
package event_fifo_pkg;

  localparam int FIFO_WIDTH = 72;
  localparam int MAX_DEGREE = 16;
  localparam int MAX_CH     = 8;

  localparam string READ_STD  = "std";
  localparam string READ_FWFT = "fwft";

  // First requesting channel at or after ptr, wrapping at num_ch.
  // Returns ptr when nothing requests; callers gate on |req.
  function automatic int rr_pick(input logic [MAX_CH-1:0] req,
                                 input int ptr,
                                 input int num_ch);
    int   pick;
    int   idx;
    logic found;
    pick  = ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (!found && i < num_ch) begin
        idx = ptr + i;
        if (idx >= num_ch) idx = idx - num_ch;
        if (req[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/event_fifo_arb_if.sv
// event_fifo_arb_if: producer and consumer signals of event_fifo_arb.
//   Producer side : wr_en[c], din[c*WIDTH +: WIDTH] in; full, almost_full,
//                   overflow out (one bit per channel).
//   Consumer side : fifo_rd_en in; fifo_dout, fifo_ch_id, fifo_data_valid,
//                   fifo_empty, underflow out.
//   Debug         : dbg_rr_ptr exposes the arbiter pointer.
//
// Handshake: a producer write on channel c is accepted on a rising edge
// where wr_en[c]=1 and full[c]=0 (full acts as the inverted ready). The
// consumer sees a word whenever fifo_empty=0; fifo_rd_en on such a cycle
// takes it (std: word shows with fifo_data_valid one cycle later; fwft: the
// word already on fifo_dout with fifo_data_valid=1 is the one consumed).
// fifo_rd_en while fifo_empty=1 is an underflow and moves no data.
//
// master: the producers/consumer environment. slave: the FIFO.
interface event_fifo_arb_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 72
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       wr_en;
  logic [NUM_CH*WIDTH-1:0] din;
  logic [NUM_CH-1:0]       full;
  logic [NUM_CH-1:0]       almost_full;
  logic [NUM_CH-1:0]       overflow;

  logic                    fifo_rd_en;
  logic [WIDTH-1:0]        fifo_dout;
  logic [CH_W-1:0]         fifo_ch_id;
  logic                    fifo_data_valid;
  logic                    fifo_empty;
  logic                    underflow;

  logic [CH_W-1:0]         dbg_rr_ptr;

  modport master (
    output wr_en, din, fifo_rd_en,
    input  full, almost_full, overflow,
    input  fifo_dout, fifo_ch_id, fifo_data_valid, fifo_empty, underflow,
    input  dbg_rr_ptr
  );

  modport slave (
    input  wr_en, din, fifo_rd_en,
    output full, almost_full, overflow,
    output fifo_dout, fifo_ch_id, fifo_data_valid, fifo_empty, underflow,
    output dbg_rr_ptr
  );

endinterface

// File: rtl/event_fifo_arb_ch.sv
// event_fifo_ch: one producer channel of event_fifo_arb.
//   clk, rstn    clock, async active-low reset
//   flush        synchronous clear (beats write and pop)
//   wr_en, din   producer write
//   pop          arbiter takes the head word this cycle
//   head         word at the read pointer
//   not_empty    count > 0
//   full         count == DEPTH
//   almost_full  count >= AFULL_TH
//   overflow     sticky: write attempted while full
module event_fifo_ch #(
  parameter int WIDTH    = 72,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 14
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             full,
  output logic             almost_full,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop_ok;

  // full comes from the registered count, so a pop in the same cycle does
  // not make room for a write to a full channel.
  assign push   = wr_en && !full;
  assign pop_ok = pop && not_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Storage has no reset; contents behind the pointers are don't-care.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head        = mem[rd_ptr];
  assign not_empty   = (count != '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AFULL_TH));

endmodule

// File: rtl/event_fifo_arb.sv
// event_fifo_arb: NUM_CH private event FIFOs merged round-robin onto one
// graph_conv style consumer port (fifo_dout/fifo_data_valid/fifo_empty/
// fifo_rd_en) plus a source-channel tag.
//   clk    clock, rising edge
//   rstn   async active-low reset
//   flush  synchronous clear of all channels, arbiter and output stage
//   bus    event_fifo_arb_if slave (producer writes, consumer reads, flags)
// READ_MODE "std": registered read, fifo_data_valid pulses the cycle after
// an accepted fifo_rd_en. READ_MODE "fwft": a one-entry output stage shows
// the next word before it is requested.
module event_fifo_arb
  import event_fifo_pkg::*;
#(
  parameter int    NUM_CH    = 4,
  parameter int    WIDTH     = FIFO_WIDTH,
  parameter int    DEPTH     = MAX_DEGREE,
  parameter string READ_MODE = READ_STD,
  parameter int    AFULL_TH  = DEPTH - 2
) (
  input logic             clk,
  input logic             rstn,
  input logic             flush,
  event_fifo_arb_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [WIDTH-1:0]  heads [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] pop;
  logic [MAX_CH-1:0] req_pad;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   rr_ptr;
  logic              any_req;
  logic              take;       // a word leaves the channels this cycle
  logic              empty_o;
  logic [WIDTH-1:0]  dout_q;
  logic [CH_W-1:0]   ch_q;
  logic              valid_q;
  logic              underflow_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    event_fifo_ch #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AFULL_TH(AFULL_TH)
    ) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush),
      .wr_en      (bus.wr_en[c]),
      .din        (bus.din[c*WIDTH +: WIDTH]),
      .pop        (pop[c]),
      .head       (heads[c]),
      .not_empty  (req[c]),
      .full       (bus.full[c]),
      .almost_full(bus.almost_full[c]),
      .overflow   (bus.overflow[c])
    );
  end

  assign any_req = |req;

  always_comb begin
    req_pad = '0;
    req_pad[NUM_CH-1:0] = req;
    grant = CH_W'(rr_pick(req_pad, int'(rr_ptr), NUM_CH));
  end

  always_comb begin
    pop = '0;
    if (take) pop[grant] = 1'b1;
  end

  // Pointer moves past the channel just served, so every requester gets a
  // turn before the same channel is served again.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
    end else if (take) begin
      rr_ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
    end
  end

  if (READ_MODE == READ_FWFT) begin : g_fwft
    // Stage refills in the same cycle it is consumed: 1 word/cycle.
    assign take    = any_req && (!valid_q || bus.fifo_rd_en) && !flush;
    assign empty_o = !valid_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        dout_q  <= '0;
        ch_q    <= '0;
        valid_q <= 1'b0;
      end else if (flush) begin
        dout_q  <= '0;
        ch_q    <= '0;
        valid_q <= 1'b0;
      end else if (take) begin
        dout_q  <= heads[grant];
        ch_q    <= grant;
        valid_q <= 1'b1;
      end else if (bus.fifo_rd_en) begin
        valid_q <= 1'b0;
      end
    end
  end else begin : g_std
    assign take    = bus.fifo_rd_en && any_req && !flush;
    assign empty_o = !any_req;

    // Data/tag hold their last value; only valid pulses.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        dout_q  <= '0;
        ch_q    <= '0;
        valid_q <= 1'b0;
      end else if (flush) begin
        dout_q  <= '0;
        ch_q    <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= take;
        if (take) begin
          dout_q <= heads[grant];
          ch_q   <= grant;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      underflow_q <= 1'b0;
    end else if (flush) begin
      underflow_q <= 1'b0;
    end else if (bus.fifo_rd_en && empty_o) begin
      underflow_q <= 1'b1;
    end
  end

  assign bus.fifo_dout       = dout_q;
  assign bus.fifo_ch_id      = ch_q;
  assign bus.fifo_data_valid = valid_q;
  assign bus.fifo_empty      = empty_o;
  assign bus.underflow       = underflow_q;
  assign bus.dbg_rr_ptr      = rr_ptr;

endmodule

// File: doc/event_fifo_arb.md
# event_fifo_arb

Multi-channel event FIFO with round-robin merge, the parametrised successor of the single-channel neighbour FIFO that feeds graph_conv. NUM_CH producers each push FIFO_WIDTH-bit event/neighbour words into private channel FIFOs. A round-robin arbiter drains them into one consumer port that is pin-compatible with graph_conv's fifo_dout/fifo_data_valid/fifo_empty/fifo_rd_en handshake, plus a channel tag. Supports std and first-word-fall-through (fwft) read modes, almost-full back-pressure, flush and sticky error flags.

## Interface
- NUM_CH, 4: producer channels, 1..8
- WIDTH, 72: data word width
- DEPTH, 16: entries per channel, power of 2, ≥ 2
- READ_MODE, "std": "std" or "fwft"
- AFULL_TH, DEPTH-2: almost_full asserts when count ≥ AFULL_TH
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all channels and the output stage
- wr_en  in  NUM_CH  per-channel write strobe
- din  in  NUM_CH*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- full  out  NUM_CH  count == DEPTH
- almost_full  out  NUM_CH  count ≥ AFULL_TH
- fifo_rd_en  in  1  consumer read/acknowledge
- fifo_dout  out  WIDTH  merged data
- fifo_ch_id  out  $clog2(NUM_CH) (min 1)  source channel of fifo_dout
- fifo_data_valid  out  1  fifo_dout/fifo_ch_id valid
- fifo_empty  out  1  no word available to consumer
- overflow  out  NUM_CH  sticky: write attempted while full
- underflow  out  1  sticky: fifo_rd_en while fifo_empty

## Operation
- Per channel: circular buffer, rd/wr pointers $clog2(DEPTH) bits wrapping at DEPTH, count $clog2(DEPTH)+1 bits. full/almost_full are decoded from registered count.
- Write accepted iff wr_en[c] && count<DEPTH; a write while full is dropped and sets overflow[c]. A write to a full channel is rejected even if the same channel is popped that cycle.
- Simultaneous push and pop on a non-full, non-empty channel: count unchanged, both pointers advance.
- Arbiter: rr_ptr (reset 0). Grant = first channel with count>0 searching rr_ptr, rr_ptr+1, … mod NUM_CH. On a pop, rr_ptr ← grant+1 mod NUM_CH. rr_ptr is unchanged when nothing is popped.
- std mode:
  - fifo_empty = all counts zero (combinational from registers).
  - fifo_rd_en && !fifo_empty pops the granted channel; fifo_dout/fifo_ch_id register the head; fifo_data_valid pulses high the next cycle.
  - fifo_rd_en while fifo_empty: no pop, fifo_data_valid stays 0, underflow set.
- fwft mode:
  - A one-entry output stage holds the word; fifo_data_valid = stage full; fifo_empty = !fifo_data_valid.
  - Stage loads from the grant when empty or when fifo_rd_en consumes it the same cycle, so back-to-back reads sustain 1 word/cycle.
  - fifo_rd_en with stage empty sets underflow.
- flush has priority over every write and read in that cycle. It clears pointers, counts, rr_ptr, output stage, fifo_data_valid, overflow and underflow. Memory contents are don't-care.
- Reset: full=0, almost_full=0, fifo_empty=1, fifo_data_valid=0, fifo_dout=0, fifo_ch_id=0, overflow=0, underflow=0; rr_ptr and all counts 0.

## Timing
- Write at edge E0 → channel count updated after E0 → fifo_empty low in cycle E0+1 (std).
- std: fifo_rd_en sampled at E1 → fifo_data_valid high for the cycle after E1 only. Read latency 1.
- fwft: stage loads at E1 → fifo_data_valid high after E1 until consumed. Write-to-valid latency 2.
- Throughput: 1 word/cycle aggregate. No combinational path from fifo_rd_en to fifo_dout.
- Async reset mid-transfer drops all stored words immediately. Outputs reach reset values without a clock.

## Structure
- Package event_fifo_pkg:
  - FIFO_WIDTH=72, MAX_DEGREE=16.
  - Read-mode constants.
  - Function rr_pick(req, ptr) returning the grant index.
- Sub-module event_fifo_ch: one channel's memory, pointers, count, full/almost_full/overflow. It exposes the head word and a pop input.
- The top level instantiates NUM_CH event_fifo_ch, the arbiter and the std/fwft output stage (generate on READ_MODE).

## Test plan
- std, NUM_CH=4: one word 0xA0 on ch2; rd_en the next cycle → fifo_data_valid one cycle later, fifo_dout=0xA0, fifo_ch_id=2, fifo_empty=1 afterward.
- All 4 channels hold 3 words each; hold rd_en for 12 cycles → fifo_ch_id sequence 0,1,2,3,0,1,2,3,… with no bubbles.
- Fill ch0 with 16 writes → full[0]=1 and almost_full[0] from the 14th write. A 17th write is dropped and sets overflow[0]=1. Same-cycle push+pop at full → push rejected, count=15.
- fwft: write ch1 at E0 → fifo_data_valid high after E0+1 with data present before rd_en. rd_en on an empty FIFO → underflow=1.
- Random writes/reads; flush asserted together with wr_en on all channels → next cycle all empty, flags 0, no words emitted.
- Assert rstn low mid-burst → outputs reach reset values asynchronously, and no stale word appears after release.
